// File: rtl/mips_core_pkg.sv
// Shared types for the branch prediction / resolution path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   PC_WIDTH           width of a PC or branch target
//   BranchOutcome      NOT_TAKEN / TAKEN
//   branch_inflight_t  one predicted branch waiting for resolution
package mips_core_pkg;

  localparam int unsigned PC_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  // recovery holds the opposite-path target. Fetch jumps there if the
  // prediction turns out to be wrong.
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    BranchOutcome        prediction;
    logic [PC_WIDTH-1:0] recovery;
  } branch_inflight_t;

endpackage

// File: rtl/branch_inflight_fifo.sv
// In-order store of predicted branches waiting for EX resolution.
// Latency: a pushed entry is visible at o_head on the cycle after the push. o_head is read combinationally.
// Backpressure: none inside this block. The caller must not push when full unless it pops in the same cycle.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   i_push, i_din     write one entry at the tail
//   i_pop             retire the head entry
//   i_clear           empty the FIFO; wins over a push or pop in the same cycle
//   o_head            oldest entry
//   o_count           occupancy, 0..DEPTH
module branch_inflight_fifo
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  branch_inflight_t           i_din,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output branch_inflight_t           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  branch_inflight_t   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage needs no reset. Occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) mem_q[wr_ptr_q] <= i_din;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Holds in-flight branch predictions and retires them in order as EX resolves them. It drives predictor feedback and the mispredict redirect.
// Latency: feedback and redirect are registered, one cycle after the resolving pop.
// Backpressure: o_pred_ready drops only when the FIFO is full and no resolve frees a slot in the same cycle.
//
// Ports:
//   clk, rst_n                                 clock, asynchronous active-low reset
//   i_pred_*  / o_pred_ready                   decode pushes a predicted branch
//   i_res_valid, i_res_outcome                 EX resolves the oldest branch
//   i_flush                                    squash all in-flight entries
//   o_fb_*                                     one-cycle feedback strobe to the predictor
//   o_redirect_valid, o_redirect_target        one-cycle mispredict redirect
//   o_count, o_err, o_branch_cnt, o_mispred_cnt  occupancy, sticky error, statistics
module branch_resolver
  import mips_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = PC_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_pred_valid,
  input  logic [ADDR_WIDTH-1:0]   i_pred_pc,
  input  logic                    i_pred_prediction,
  input  logic [ADDR_WIDTH-1:0]   i_pred_recovery,
  output logic                    o_pred_ready,
  input  logic                    i_res_valid,
  input  logic                    i_res_outcome,
  input  logic                    i_flush,
  output logic                    o_fb_valid,
  output logic [ADDR_WIDTH-1:0]   o_fb_pc,
  output logic                    o_fb_prediction,
  output logic                    o_fb_outcome,
  output logic                    o_redirect_valid,
  output logic [ADDR_WIDTH-1:0]   o_redirect_target,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_err,
  output logic [CNT_WIDTH-1:0]    o_branch_cnt,
  output logic [CNT_WIDTH-1:0]    o_mispred_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  branch_inflight_t push_dat;
  branch_inflight_t head;
  logic [CW-1:0]    count;
  logic             pop, mispred, push, clear;

  logic                  fb_valid_q,   fb_valid_d;
  logic [ADDR_WIDTH-1:0] fb_pc_q,      fb_pc_d;
  logic                  fb_pred_q,    fb_pred_d;
  logic                  fb_out_q,     fb_out_d;
  logic                  redir_vld_q,  redir_vld_d;
  logic [ADDR_WIDTH-1:0] redir_tgt_q,  redir_tgt_d;
  logic                  err_q,        err_d;
  logic [CNT_WIDTH-1:0]  br_cnt_q,     br_cnt_d;
  logic [CNT_WIDTH-1:0]  mp_cnt_q,     mp_cnt_d;

  always_comb begin
    push_dat.pc         = i_pred_pc;
    push_dat.prediction = BranchOutcome'(i_pred_prediction);
    push_dat.recovery   = i_pred_recovery;
  end

  assign pop          = i_res_valid && (count != '0);
  assign mispred      = pop && (logic'(head.prediction) != i_res_outcome);
  assign o_pred_ready = (count < CW'(DEPTH)) || i_res_valid;
  // A push in the cycle of a mispredict or flush is on the wrong path, so it
  // is dropped. The handshake still completes and decode sees it as taken.
  assign push         = i_pred_valid && o_pred_ready && !i_flush && !mispred;
  assign clear        = i_flush || mispred;

  branch_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (push),
    .i_din   (push_dat),
    .i_pop   (pop),
    .i_clear (clear),
    .o_head  (head),
    .o_count (count)
  );

  always_comb begin
    fb_valid_d  = pop;
    fb_pc_d     = fb_pc_q;
    fb_pred_d   = fb_pred_q;
    fb_out_d    = fb_out_q;
    redir_vld_d = mispred;
    redir_tgt_d = redir_tgt_q;
    err_d       = err_q || (i_res_valid && (count == '0));
    br_cnt_d    = br_cnt_q;
    mp_cnt_d    = mp_cnt_q;
    if (pop) begin
      fb_pc_d   = head.pc;
      fb_pred_d = head.prediction;
      fb_out_d  = i_res_outcome;
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
    end
    if (mispred) begin
      redir_tgt_d = head.recovery;
      if (mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_valid_q  <= 1'b0;
      fb_pc_q     <= '0;
      fb_pred_q   <= 1'b0;
      fb_out_q    <= 1'b0;
      redir_vld_q <= 1'b0;
      redir_tgt_q <= '0;
      err_q       <= 1'b0;
      br_cnt_q    <= '0;
      mp_cnt_q    <= '0;
    end else begin
      fb_valid_q  <= fb_valid_d;
      fb_pc_q     <= fb_pc_d;
      fb_pred_q   <= fb_pred_d;
      fb_out_q    <= fb_out_d;
      redir_vld_q <= redir_vld_d;
      redir_tgt_q <= redir_tgt_d;
      err_q       <= err_d;
      br_cnt_q    <= br_cnt_d;
      mp_cnt_q    <= mp_cnt_d;
    end
  end

  assign o_fb_valid        = fb_valid_q;
  assign o_fb_pc           = fb_pc_q;
  assign o_fb_prediction   = fb_pred_q;
  assign o_fb_outcome      = fb_out_q;
  assign o_redirect_valid  = redir_vld_q;
  assign o_redirect_target = redir_tgt_q;
  assign o_count           = count;
  assign o_err             = err_q;
  assign o_branch_cnt      = br_cnt_q;
  assign o_mispred_cnt     = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv, pp, rv, ro, fl;
  logic [31:0] ppc, prec;
  logic        ready, fbv, fbp, fbo, rdv, err;
  logic [31:0] fbpc, rdt;
  logic [2:0]  cnt;
  logic [15:0] bcnt, mcnt;

  // Saturation instance with narrow counters.
  logic        s_pv, s_pp, s_rv, s_ro;
  logic [31:0] s_ppc, s_prec;
  logic        s_ready, s_fbv, s_fbp, s_fbo, s_rdv, s_err;
  logic [31:0] s_fbpc, s_rdt;
  logic [1:0]  s_cnt;
  logic [3:0]  s_bcnt, s_mcnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic        outc;
    logic        redir;
    logic [31:0] tgt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_resolver #(.ADDR_WIDTH(32), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pred_valid(pv), .i_pred_pc(ppc), .i_pred_prediction(pp), .i_pred_recovery(prec),
    .o_pred_ready(ready), .i_res_valid(rv), .i_res_outcome(ro), .i_flush(fl),
    .o_fb_valid(fbv), .o_fb_pc(fbpc), .o_fb_prediction(fbp), .o_fb_outcome(fbo),
    .o_redirect_valid(rdv), .o_redirect_target(rdt), .o_count(cnt), .o_err(err),
    .o_branch_cnt(bcnt), .o_mispred_cnt(mcnt)
  );

  branch_resolver #(.ADDR_WIDTH(32), .DEPTH(2), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .i_pred_valid(s_pv), .i_pred_pc(s_ppc), .i_pred_prediction(s_pp), .i_pred_recovery(s_prec),
    .o_pred_ready(s_ready), .i_res_valid(s_rv), .i_res_outcome(s_ro), .i_flush(1'b0),
    .o_fb_valid(s_fbv), .o_fb_pc(s_fbpc), .o_fb_prediction(s_fbp), .o_fb_outcome(s_fbo),
    .o_redirect_valid(s_rdv), .o_redirect_target(s_rdt), .o_count(s_cnt), .o_err(s_err),
    .o_branch_cnt(s_bcnt), .o_mispred_cnt(s_mcnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pv = 0; pp = 0; ppc = '0; prec = '0; rv = 0; ro = 0; fl = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred, input logic [31:0] rec);
    pv = 1; ppc = pc; pp = pred; prec = rec;
    step();
    pv = 0;
  endtask

  // Issue one resolve. The expected feedback is queued for the monitor.
  task automatic resolve(input logic outc, input logic [31:0] pc, input logic pred,
                         input logic [31:0] rec);
    exp_t e;
    e.pc = pc; e.pred = pred; e.outc = outc; e.redir = (pred != outc); e.tgt = rec;
    sb.push_back(e);
    rv = 1; ro = outc;
    step();
    rv = 0;
  endtask

  // Monitor: compares every feedback strobe against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fbv === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL fb_unexpected: got fb_pc 0x%0h with no pending resolve", fbpc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("fb_pc", fbpc, e.pc);
          chk("fb_pred", fbp, e.pred);
          chk("fb_outcome", fbo, e.outc);
          chk("redir_vld", rdv, e.redir);
          if (e.redir) chk("redir_tgt", rdt, e.tgt);
        end
      end else if (rdv !== 1'b0) begin
        total++; bad++;
        $display("FAIL redir_alone: got redirect 0x%0h without feedback", rdv);
      end
    end
  end

  initial begin
    rst_n = 1; idle();
    s_pv = 0; s_pp = 0; s_ppc = '0; s_prec = '0; s_rv = 0; s_ro = 0;
    // Reset asserted mid-cycle takes effect immediately.
    #3 rst_n = 0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_fbv", fbv, 0);
    chk("rst_fbpc", fbpc, 0);
    chk("rst_rdv", rdv, 0);
    chk("rst_rdt", rdt, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_bcnt", bcnt, 0);
    chk("rst_mcnt", mcnt, 0);
    step(); step();
    rst_n = 1;
    step();

    // Correct prediction.
    push(32'h100, 1, 32'h108);
    chk("t1_cnt1", cnt, 1);
    resolve(1, 32'h100, 1, 32'h108);
    chk("t1_cnt0", cnt, 0);
    chk("t1_bcnt", bcnt, 1);
    chk("t1_mcnt", mcnt, 0);

    // Mispredict squashes the younger entries and drops a concurrent push.
    push(32'h100, 1, 32'h108);
    push(32'h200, 0, 32'h204);
    push(32'h300, 1, 32'h308);
    chk("t2_cnt3", cnt, 3);
    pv = 1; ppc = 32'h400; pp = 1; prec = 32'h408;
    resolve(0, 32'h100, 1, 32'h108);
    pv = 0;
    chk("t2_cnt0", cnt, 0);
    chk("t2_mcnt", mcnt, 1);
    chk("t2_bcnt", bcnt, 2);

    // Full FIFO: a lone push is refused, and a push paired with a resolve is accepted.
    push(32'h10, 0, 32'h14);
    push(32'h20, 0, 32'h24);
    push(32'h30, 0, 32'h34);
    push(32'h40, 0, 32'h44);
    chk("t3_full", cnt, 4);
    pv = 1; ppc = 32'h50; pp = 0; prec = 32'h54;
    #1 chk("t3_ready0", ready, 0);
    step();
    chk("t3_cnt_hold", cnt, 4);
    rv = 1; ro = 0;
    #1 chk("t3_ready1", ready, 1);
    resolve(0, 32'h10, 0, 32'h14);
    pv = 0;
    chk("t3_cnt4", cnt, 4);
    resolve(0, 32'h20, 0, 32'h24);
    resolve(0, 32'h30, 0, 32'h34);
    resolve(0, 32'h40, 0, 32'h44);
    resolve(0, 32'h50, 0, 32'h54);
    chk("t3_drained", cnt, 0);
    chk("t3_bcnt", bcnt, 7);

    // Flush with a concurrent correct resolve still emits feedback.
    push(32'hA00, 1, 32'hA08);
    push(32'hB00, 1, 32'hB08);
    chk("t4_cnt2", cnt, 2);
    fl = 1; pv = 1; ppc = 32'hC00; pp = 1; prec = 32'hC08;
    resolve(1, 32'hA00, 1, 32'hA08);
    fl = 0; pv = 0;
    chk("t4_cnt0", cnt, 0);
    chk("t4_mcnt", mcnt, 1);

    // Resolve while empty.
    rv = 1; ro = 1;
    step();
    rv = 0;
    chk("t5_err", err, 1);
    chk("t5_fbv", fbv, 0);
    chk("t5_cnt", cnt, 0);
    chk("t5_bcnt", bcnt, 8);
    push(32'hD00, 1, 32'hD08);
    resolve(1, 32'hD00, 1, 32'hD08);
    chk("t5_err_sticky", err, 1);

    // A reset during operation drops the pending feedback and redirect pulse.
    push(32'hE00, 1, 32'hE08);
    resolve(0, 32'hE00, 1, 32'hE08);
    rst_n = 0;
    #1;
    sb.delete();
    chk("mrst_fbv", fbv, 0);
    chk("mrst_rdv", rdv, 0);
    chk("mrst_err", err, 0);
    chk("mrst_cnt", cnt, 0);
    chk("mrst_ready", ready, 1);
    chk("mrst_bcnt", bcnt, 0);
    step();
    rst_n = 1;
    step();

    // Counters saturate at all-ones.
    for (int i = 0; i < 17; i++) begin
      s_pv = 1; s_ppc = 32'h1000 + i; s_pp = 1; s_prec = 32'h2000 + i;
      step();
      s_pv = 0; s_rv = 1; s_ro = 0;
      step();
      s_rv = 0;
      if (i == 13) begin
        chk("sat_b14", s_bcnt, 14);
        chk("sat_m14", s_mcnt, 14);
      end
    end
    chk("sat_bcnt", s_bcnt, 4'hF);
    chk("sat_mcnt", s_mcnt, 4'hF);

    step(); step();
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
